// File: rtl/nn_loader_pkg.sv
// Shared constants and state encoding for the nn_input_loader slice.
// Optional build macro: NN_LOADER_TIMEOUT_EN (adds the default inter-byte timeout).
package nn_loader_pkg;

    localparam int unsigned DEF_NUM_PIXELS = 784;
    localparam int unsigned DEF_DATA_W     = 8;
    localparam int unsigned DEF_ADDR_W     = 10;
    localparam int unsigned CLASS_W        = 4;
    localparam logic [7:0]  DEF_SYNC_BYTE  = 8'hA5;
`ifdef NN_LOADER_TIMEOUT_EN
    localparam int unsigned DEF_TIMEOUT_CYCLES = 1_000_000;
`endif

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_FIRE   = 3'd2,
        ST_WAIT   = 3'd3,
        ST_REPORT = 3'd4
    } state_t;

endpackage

// File: rtl/nn_loader_timeout.sv
// Inter-byte watchdog: reloads on load, counts down while enabled, flags expiry.
module nn_loader_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic expire_c
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q;

    // Down-counter: reload to TIMEOUT_CYCLES-1, then step toward zero while enabled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= CNT_W'(TIMEOUT_CYCLES - 1);
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // Expiry lands on the TIMEOUT_CYCLES-th idle cycle after the reload
    assign expire_c = en && (cnt_q == '0);

endmodule

// File: rtl/nn_input_loader.sv
// Framed pixel-stream loader: sync byte, NUM_PIXELS writes, start, wait done, report argmax.
// Optional build macro: NN_LOADER_TIMEOUT_EN (inter-byte timeout in LOAD, sticky error).
module nn_input_loader
    import nn_loader_pkg::*;
#(
    parameter int unsigned        NUM_PIXELS = DEF_NUM_PIXELS,
    parameter int unsigned        DATA_W     = DEF_DATA_W,
    parameter int unsigned        ADDR_W     = DEF_ADDR_W,
    parameter logic [DATA_W-1:0]  SYNC_BYTE  = DATA_W'(DEF_SYNC_BYTE)
`ifdef NN_LOADER_TIMEOUT_EN
    ,
    parameter int unsigned        TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                s_valid,
    input  logic [DATA_W-1:0]   s_data,
    output logic                s_ready,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic                nn_start,
    input  logic                nn_done,
    input  logic [CLASS_W-1:0]  nn_argmax,
    output logic                result_valid,
    output logic [CLASS_W-1:0]  result,
    output logic                busy,
    output logic                error,
    output logic [2:0]          state
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    pix_cnt_q, pix_cnt_d;
    logic                 wait_first_q, wait_first_d;
    logic                 error_q, error_d;
    logic                 s_ready_d, mem_we_d, nn_start_d, result_valid_d, busy_d;
    logic [ADDR_W-1:0]    mem_addr_d;
    logic [DATA_W-1:0]    mem_wdata_d;
    logic [CLASS_W-1:0]   result_d;
    logic                 xfer;

    assign xfer  = s_valid && s_ready;
    assign state = state_q;
    assign error = error_q;

`ifdef NN_LOADER_TIMEOUT_EN
    logic to_load, to_en, expire_c;

    // Held loaded outside LOAD and on every transfer; counts only idle LOAD cycles
    assign to_load = (state_q != ST_LOAD) || xfer;
    assign to_en   = (state_q == ST_LOAD) && !xfer;

    nn_loader_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .load     (to_load),
        .en       (to_en),
        .expire_c (expire_c)
    );
`endif

    // State register and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            pix_cnt_q    <= '0;
            wait_first_q <= 1'b0;
            error_q      <= 1'b0;
            s_ready      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            nn_start     <= 1'b0;
            result_valid <= 1'b0;
            result       <= '0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            pix_cnt_q    <= pix_cnt_d;
            wait_first_q <= wait_first_d;
            error_q      <= error_d;
            s_ready      <= s_ready_d;
            mem_we       <= mem_we_d;
            mem_addr     <= mem_addr_d;
            mem_wdata    <= mem_wdata_d;
            nn_start     <= nn_start_d;
            result_valid <= result_valid_d;
            result       <= result_d;
            busy         <= busy_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        pix_cnt_d    = pix_cnt_q;
        wait_first_d = 1'b0;
        error_d      = error_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        result_d     = result;

        case (state_q)
            ST_IDLE: begin
                if (xfer && (s_data == SYNC_BYTE)) begin
                    state_d   = ST_LOAD;
                    pix_cnt_d = '0;
                    error_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                // Sync bytes here are ordinary pixel data
                if (xfer) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = pix_cnt_q;
                    mem_wdata_d = s_data;
                    pix_cnt_d   = pix_cnt_q + ADDR_W'(1);
                    if (pix_cnt_q == LAST_ADDR) begin
                        state_d = ST_FIRE;
                    end
                end
`ifdef NN_LOADER_TIMEOUT_EN
                else if (expire_c) begin
                    state_d = ST_IDLE;
                    error_d = 1'b1;
                end
`endif
            end
            ST_FIRE: begin
                state_d      = ST_WAIT;
                wait_first_d = 1'b1;
            end
            ST_WAIT: begin
                // First WAIT cycle may still see done from the previous run
                if (!wait_first_q && nn_done) begin
                    result_d = nn_argmax;
                    state_d  = ST_REPORT;
                end
            end
            ST_REPORT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        s_ready_d      = (state_d == ST_IDLE) || (state_d == ST_LOAD);
        busy_d         = (state_d != ST_IDLE);
        result_valid_d = (state_d == ST_REPORT);
        // Registered off FIRE so start lands one cycle after the last pixel write
        nn_start_d     = (state_q == ST_FIRE);
    end

endmodule

// File: tb/tb_nn_input_loader.sv
// Self-checking bench for nn_input_loader: frame vectors, write scoreboard, corner sequences.
module tb_nn_input_loader;

    localparam int unsigned NPIX = 784;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_ready;
    logic       mem_we;
    logic [9:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       nn_start;
    logic       nn_done = 1'b0;
    logic [3:0] nn_argmax = 4'd0;
    logic       result_valid;
    logic [3:0] result;
    logic       busy;
    logic       error;
    logic [2:0] state;

    always #5 clk = ~clk;

    nn_input_loader #(
        .NUM_PIXELS (NPIX)
`ifdef NN_LOADER_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (100)
`endif
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .nn_start     (nn_start),
        .nn_done      (nn_done),
        .nn_argmax    (nn_argmax),
        .result_valid (result_valid),
        .result       (result),
        .busy         (busy),
        .error        (error),
        .state        (state)
    );

    typedef struct {
        int         junk_n;
        int         gap_pct;
        bit         inject;
        bit         stale;
        logic [3:0] argmax;
        logic [3:0] exp_result;
    } vec_t;

    typedef struct packed {
        logic [9:0] addr;
        logic [7:0] data;
    } wr_t;

    vec_t       vecs [4];
    wr_t        exp_q [$];
    wr_t        mon_e;
    logic [9:0] exp_addr = 10'd0;
    logic [7:0] jb [3] = '{8'h00, 8'hFF, 8'h12};
    int         n_checks = 0;
    int         n_fail = 0;
    int         frame_writes = 0;
    int         frame_starts = 0;
    int         frame_rv = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every write must match the next expected pixel
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_we) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("wr_addr", 32'(mem_addr), 32'(mon_e.addr));
                    check("wr_data", 32'(mem_wdata), 32'(mon_e.data));
                end
                frame_writes++;
            end
            if (nn_start) begin
                frame_starts++;
                check("start_after_last_write", 32'(mem_we), 32'd0);
                check("writes_before_start", 32'(frame_writes), 32'(NPIX));
            end
            if (result_valid) frame_rv++;
        end
    end

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) begin
            s_data = 8'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit payload);
        bit ok;
        ok = 1'b0;
        s_valid = 1'b1;
        s_data  = b;
        for (int k = 0; k < 50; k++) begin
            if (s_ready) begin
                if (payload) begin
                    exp_q.push_back('{addr: exp_addr, data: b});
                    exp_addr++;
                end
                ok = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        s_valid = 1'b0;
        s_data  = 8'($urandom);
        check("handshake", 32'(ok), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_ready"},      32'(s_ready), 32'd0);
        check({tag, "_mem_we"},       32'(mem_we), 32'd0);
        check({tag, "_mem_addr"},     32'(mem_addr), 32'd0);
        check({tag, "_mem_wdata"},    32'(mem_wdata), 32'd0);
        check({tag, "_nn_start"},     32'(nn_start), 32'd0);
        check({tag, "_result_valid"}, 32'(result_valid), 32'd0);
        check({tag, "_result"},       32'(result), 32'd0);
        check({tag, "_busy"},         32'(busy), 32'd0);
        check({tag, "_error"},        32'(error), 32'd0);
        check({tag, "_state"},        32'(state), 32'd0);
    endtask

    // Asynchronous reset pulse, asserted away from any clock edge
    task automatic reset_pulse(input string tag);
        @(negedge clk);
        #3 reset = 1'b1;
        #1 check_reset_outputs(tag);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        exp_addr = 10'd0;
        @(negedge clk);
    endtask

    task automatic run_frame(input vec_t v, input string tag);
        bit         seen;
        logic [7:0] b;
        frame_writes = 0;
        frame_starts = 0;
        frame_rv     = 0;
        exp_addr     = 10'd0;
        nn_done      = v.stale;
        nn_argmax    = v.stale ? 4'd3 : 4'd0;
        for (int j = 0; j < v.junk_n; j++) send_byte(jb[j], 1'b0);
        check({tag, "_no_write_before_sync"}, 32'(frame_writes), 32'd0);
        check({tag, "_idle_before_sync"}, 32'(state), 32'd0);
        send_byte(8'hA5, 1'b0);
        check({tag, "_state_load"}, 32'(state), 32'd1);
        check({tag, "_busy_load"}, 32'(busy), 32'd1);
        for (int i = 0; i < int'(NPIX); i++) begin
            if ((v.gap_pct > 0) && (int'($urandom_range(99)) < v.gap_pct))
                idle(int'($urandom_range(3, 1)));
            b = (v.inject && (i % 37 == 5)) ? 8'hA5 : 8'(i);
            send_byte(b, 1'b1);
        end
        // Offer a further byte: it must not be taken
        s_valid = 1'b1;
        s_data  = 8'h55;
        check({tag, "_s_ready_drop"}, 32'(s_ready), 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (nn_start) begin seen = 1'b1; break; end
        end
        check({tag, "_start_seen"}, 32'(seen), 32'd1);
        check({tag, "_state_wait"}, 32'(state), 32'd3);
        if (v.stale) @(negedge clk);
        nn_done   = 1'b0;
        nn_argmax = v.argmax;
        repeat (3) @(negedge clk);
        nn_done = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (result_valid) begin seen = 1'b1; break; end
        end
        s_valid = 1'b0;
        check({tag, "_rv_seen"}, 32'(seen), 32'd1);
        check({tag, "_result"}, 32'(result), 32'(v.exp_result));
        check({tag, "_state_report"}, 32'(state), 32'd4);
        nn_done = 1'b0;
        @(negedge clk);
        check({tag, "_rv_pulse"}, 32'(result_valid), 32'd0);
        check({tag, "_busy_idle"}, 32'(busy), 32'd0);
        check({tag, "_state_idle"}, 32'(state), 32'd0);
        check({tag, "_s_ready_idle"}, 32'(s_ready), 32'd1);
        check({tag, "_result_held"}, 32'(result), 32'(v.exp_result));
        check({tag, "_writes"}, 32'(frame_writes), 32'(NPIX));
        check({tag, "_starts"}, 32'(frame_starts), 32'd1);
        check({tag, "_rv_count"}, 32'(frame_rv), 32'd1);
        check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{junk_n: 0, gap_pct: 0,  inject: 1'b0, stale: 1'b0, argmax: 4'd7,  exp_result: 4'd7};
        vecs[1] = '{junk_n: 3, gap_pct: 0,  inject: 1'b0, stale: 1'b0, argmax: 4'd2,  exp_result: 4'd2};
        vecs[2] = '{junk_n: 0, gap_pct: 50, inject: 1'b1, stale: 1'b0, argmax: 4'd12, exp_result: 4'd12};
        vecs[3] = '{junk_n: 0, gap_pct: 0,  inject: 1'b0, stale: 1'b1, argmax: 4'd9,  exp_result: 4'd9};

        #2 reset = 1'b1;
        #1 check_reset_outputs("por");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("s_ready_after_reset", 32'(s_ready), 32'd1);

        for (int v = 0; v < 4; v++) run_frame(vecs[v], $sformatf("vec%0d", v));

        // Reset in the middle of a frame
        frame_writes = 0;
        frame_starts = 0;
        exp_addr     = 10'd0;
        send_byte(8'hA5, 1'b0);
        for (int i = 0; i <= 300; i++) send_byte(8'(i), 1'b1);
`ifndef NN_LOADER_TIMEOUT_EN
        idle(150);
        check("stall_stays_load", 32'(state), 32'd1);
        check("stall_no_error", 32'(error), 32'd0);
`endif
        check("mid_writes", 32'(frame_writes), 32'd301);
        reset_pulse("midrst");
        idle(20);
        check("midrst_no_start", 32'(frame_starts), 32'd0);
        run_frame(vecs[0], "after_rst");

`ifdef NN_LOADER_TIMEOUT_EN
        // Stall after pixel 10: timeout to IDLE with error, next sync clears it
        frame_starts = 0;
        exp_addr     = 10'd0;
        send_byte(8'hA5, 1'b0);
        for (int i = 0; i <= 10; i++) send_byte(8'(i), 1'b1);
        idle(99);
        check("to_still_load", 32'(state), 32'd1);
        check("to_no_error_yet", 32'(error), 32'd0);
        idle(1);
        check("to_state_idle", 32'(state), 32'd0);
        check("to_error_set", 32'(error), 32'd1);
        check("to_busy_low", 32'(busy), 32'd0);
        idle(10);
        check("to_error_sticky", 32'(error), 32'd1);
        check("to_no_start", 32'(frame_starts), 32'd0);
        send_byte(8'hA5, 1'b0);
        check("to_error_cleared", 32'(error), 32'd0);
        check("to_reload", 32'(state), 32'd1);
        reset_pulse("to_rst");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
